// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD test-pattern generator: pattern modes,
// RGB565 colour constants and the colour-bar lookup.
package lcd_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_GRID  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_RAMP  = 3'd4
  } mode_e;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] BLACK   = 16'h0000;

  // Bar 0 is leftmost.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = CYAN;
      3'd3:    c = GREEN;
      3'd4:    c = MAGENTA;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_timing.sv
// Horizontal/vertical raster counters; decodes sync, data-enable, active
// coordinates and the frame-start position from the current counter state.
module lcd_timing #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hs_on,
  output logic             vs_on,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_check
    $error("lcd_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hs_on       = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on       = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign de          = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign x           = de ? h_cnt : '0;
  assign y           = de ? v_cnt : '0;
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/lcd_pattern_gen.sv
// RGB565 LCD timing and test-pattern generator with a per-frame mode latch.
// Optional macro LCD_PATTERN_SCROLL_EN scrolls grid/checker/ramp by frame count.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int   H_ACTIVE = 480,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 4,
  parameter int   H_BP     = 43,
  parameter int   V_ACTIVE = 272,
  parameter int   V_FP     = 8,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 12,
  parameter int   CNT_W    = 10,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_mode,
  input  logic [15:0]      i_color,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic [4:0]       o_r,
  output logic [5:0]       o_g,
  output logic [4:0]       o_b,
  output logic             o_frame_start
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

  logic             hs_on, vs_on, de, frame_start;
  logic [CNT_W-1:0] x, y;

  lcd_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clk         (i_clk),
    .rst         (i_rst),
    .hs_on       (hs_on),
    .vs_on       (vs_on),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  logic [2:0]  mode_q;
  logic [2:0]  mode;
  logic [8:0]  px;
  logic [2:0]  bar;
  logic [15:0] pixel;

`ifdef LCD_PATTERN_SCROLL_EN
  logic [7:0] frame_cnt;
  logic [7:0] scroll;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // frame_cnt steps on the frame's first pixel, so later pixels look one back.
  assign scroll = frame_start ? frame_cnt : frame_cnt - 8'd1;
`endif

  always_comb begin
    // The first pixel of a frame already uses the mode being latched.
    mode = frame_start ? i_mode : mode_q;
`ifdef LCD_PATTERN_SCROLL_EN
    px = 9'(x) + 9'(scroll);
`else
    px = 9'(x);
`endif
    bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (x >= CNT_W'(k * H_ACTIVE / 8)) begin
        bar = 3'(k);
      end
    end
    case (mode)
      MODE_BARS:  pixel = bar_color(bar);
      MODE_GRID:  pixel = (px[3:0] == 4'd0 || y[3:0] == 4'd0 || x == X_LAST || y == Y_LAST)
                          ? WHITE : BLACK;
      MODE_CHECK: pixel = (px[4] ^ y[4]) ? WHITE : BLACK;
      MODE_RAMP:  pixel = {px[8:4], px[8:4], px[8], px[8:4]};
      default:    pixel = i_color;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q        <= MODE_SOLID;
      o_hsync       <= ~HS_POL;
      o_vsync       <= ~VS_POL;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      if (frame_start) begin
        mode_q <= i_mode;
      end
      o_hsync       <= hs_on ? HS_POL : ~HS_POL;
      o_vsync       <= vs_on ? VS_POL : ~VS_POL;
      o_de          <= de;
      o_x           <= x;
      o_y           <= y;
      o_r           <= de ? pixel[15:11] : '0;
      o_g           <= de ? pixel[10:5]  : '0;
      o_b           <= de ? pixel[4:0]   : '0;
      o_frame_start <= frame_start;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen on a small 16x8 raster, against a
// raster-position model derived from cycles elapsed since reset.
module tb_lcd_pattern_gen;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HSW = 2;
  localparam int HBP = 2;
  localparam int VA  = 8;
  localparam int VFP = 1;
  localparam int VSW = 1;
  localparam int VBP = 1;
  localparam int CW  = 10;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FT  = HT * VT;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b0;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [2:0]    i_mode;
  logic [15:0]   i_color;
  logic          o_hsync, o_vsync, o_de, o_frame_start;
  logic [CW-1:0] o_x, o_y;
  logic [4:0]    o_r, o_b;
  logic [5:0]    o_g;

  lcd_pattern_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HFP),
    .H_SYNC   (HSW),
    .H_BP     (HBP),
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_BP     (VBP),
    .CNT_W    (CW),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_mode        (i_mode),
    .i_color       (i_color),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_de          (o_de),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_r           (o_r),
    .o_g           (o_g),
    .o_b           (o_b),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: k = clocks since reset release, fmode = mode of the current frame.
  int            k = 0;
  int            fmode = 0;
  logic          e_hs, e_vs, e_de, e_fs;
  logic [CW-1:0] e_x, e_y;
  logic [4:0]    e_r, e_b;
  logic [5:0]    e_g;

  function automatic logic [15:0] bar_ref(input int idx);
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] pattern(input int mode, input int x, input int y,
                                          input logic [15:0] col, input int off);
    int px, idx, g5;
    px = (x + off) % (1 << CW);
    case (mode)
      1: begin
        idx = 0;
        for (int b = 1; b < 8; b++) if (x >= b * HA / 8) idx = b;
        return bar_ref(idx);
      end
      2: return ((px % 16 == 0) || (y % 16 == 0) || x == HA - 1 || y == VA - 1)
                ? 16'hFFFF : 16'h0000;
      3: return ((((px / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 16'hFFFF : 16'h0000;
      4: begin
        g5 = (px / 16) % 32;
        return {5'(g5), 6'(g5 * 2 + (px / 256) % 2), 5'(g5)};
      end
      default: return col;
    endcase
  endfunction

  task automatic model();
    int h, v, off;
    logic [15:0] pix;
    if (i_rst) begin
      k = 0;
      fmode = 0;
      e_hs = ~HS_POL; e_vs = ~VS_POL; e_de = 1'b0; e_fs = 1'b0;
      e_x = '0; e_y = '0; e_r = '0; e_g = '0; e_b = '0;
    end else begin
      h = k % HT;
      v = (k / HT) % VT;
      if (h == 0 && v == 0) fmode = int'(i_mode);
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HS_POL : ~HS_POL;
      e_vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VS_POL : ~VS_POL;
      e_fs = (h == 0) && (v == 0);
      e_x  = e_de ? CW'(h) : '0;
      e_y  = e_de ? CW'(v) : '0;
`ifdef LCD_PATTERN_SCROLL_EN
      off = (k / FT) % 256;
`else
      off = 0;
`endif
      pix = e_de ? pattern(fmode, h, v, i_color, off) : 16'h0000;
      {e_r, e_g, e_b} = pix;
      k++;
    end
  endtask

  task automatic compare();
    logic [39:0] got, exp;
    got = {o_hsync, o_vsync, o_de, o_frame_start, o_x, o_y, o_r, o_g, o_b};
    exp = {e_hs, e_vs, e_de, e_fs, e_x, e_y, e_r, e_g, e_b};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got=%h exp=%h (hs,vs,de,fs,x,y,r,g,b)", $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Advance until the next step() outputs pixel position (h,v).
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while ((k % FT) != v * HT + h && n < 2 * FT) begin
      step();
      n++;
    end
    check_lit("run_to_bound", int'(n < 2 * FT), 1);
  endtask

  int hl, vl, fsn;

  initial begin
    i_rst   = 1'b1;
    i_mode  = 3'd1;
    i_color = 16'hF800;
    repeat (3) step();
    check_lit("rst_hsync", int'(o_hsync), 1);
    check_lit("rst_vsync", int'(o_vsync), 1);
    check_lit("rst_de", int'(o_de), 0);
    check_lit("rst_fs", int'(o_frame_start), 0);
    check_lit("rst_rgb", int'({o_r, o_g, o_b}), 0);

    i_rst = 1'b0;
    step();
    check_lit("rel_fs", int'(o_frame_start), 1);
    check_lit("rel_de", int'(o_de), 1);
    check_lit("bars_x0", int'({o_r, o_g, o_b}), 16'hFFFF);
    step();
    check_lit("bars_x1", int'({o_r, o_g, o_b}), 16'hFFFF);
    step();
    check_lit("bars_x2", int'({o_r, o_g, o_b}), 16'hFFE0);
    run_to(14, 0); step();
    check_lit("bars_x14", int'({o_r, o_g, o_b}), 16'h0000);
    check_lit("bars_x14_de", int'(o_de), 1);
    run_to(16, 0); step();
    check_lit("blank_de", int'(o_de), 0);
    check_lit("blank_rgb", int'({o_r, o_g, o_b}), 0);

    hl = 0;
    repeat (HT) begin step(); hl += int'(o_hsync == 1'b0); end
    check_lit("hsync_low_per_line", hl, 2);
    hl = 0; vl = 0; fsn = 0;
    repeat (FT) begin
      step();
      hl  += int'(o_hsync == 1'b0);
      vl  += int'(o_vsync == 1'b0);
      fsn += int'(o_frame_start);
    end
    check_lit("hsync_low_per_frame", hl, 22);
    check_lit("vsync_low_per_frame", vl, 22);
    check_lit("fs_per_frame", fsn, 1);

    i_mode = 3'd0;
    run_to(0, 0);
    run_to(5, 3);
    i_mode = 3'd3;
    step(); step();
    check_lit("midframe_solid", int'({o_r, o_g, o_b}), 16'hF800);
    run_to(0, 0); step();
    check_lit("next_frame_fs", int'(o_frame_start), 1);
`ifndef LCD_PATTERN_SCROLL_EN
    check_lit("next_frame_checker", int'({o_r, o_g, o_b}), 16'h0000);
`endif

    i_mode = 3'd2;
    run_to(0, 0); step();
    check_lit("grid_0_0", int'({o_r, o_g, o_b}), 16'hFFFF);
    run_to(9, 0); step();
    check_lit("grid_9_0", int'({o_r, o_g, o_b}), 16'hFFFF);
`ifndef LCD_PATTERN_SCROLL_EN
    run_to(5, 1); step();
    check_lit("grid_5_1", int'({o_r, o_g, o_b}), 16'h0000);
`endif
    run_to(15, 1); step();
    check_lit("grid_15_1", int'({o_r, o_g, o_b}), 16'hFFFF);

    i_mode = 3'd0;
    run_to(7, 4);
    i_rst = 1'b1;
    step();
    check_lit("pulse_de", int'(o_de), 0);
    check_lit("pulse_hsync", int'(o_hsync), 1);
    check_lit("pulse_x", int'(o_x), 0);
    i_rst = 1'b0;
    step();
    check_lit("restart_fs", int'(o_frame_start), 1);
    check_lit("restart_xy", int'({o_x, o_y}), 0);

    repeat (40 * FT) begin
      i_color = 16'($urandom);
      if ($urandom_range(0, 99) == 0) i_mode = 3'($urandom_range(0, 7));
      i_rst = ($urandom_range(0, 1999) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
